// File: rtl/bch_encoder_p8_ctrl.sv
// bch_encoder_p8_ctrl: frame sequencer for the 8-bit-parallel BCH encoder.
// Streams info bytes into the encoder without gaps, then the parity phase,
// and emits the codeword with SOF/EOF markers. An upstream underrun aborts the frame.
module bch_encoder_p8_ctrl #(
  parameter int INFO_BYTES   = 512,
  parameter int PARITY_BYTES = 13,
  parameter int ENC_LATENCY  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] enc_message,
  output logic       enc_sel,
  output logic       enc_start,
  input  logic [7:0] enc_code,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_sof,
  output logic       out_eof,
  output logic       err_underrun,
  output logic       busy
);
  localparam int IW = (INFO_BYTES > 1) ? $clog2(INFO_BYTES) : 1;
  localparam int PW = (PARITY_BYTES > 1) ? $clog2(PARITY_BYTES) : 1;
  localparam int DW = $clog2(ENC_LATENCY + 1);
  localparam int L  = ENC_LATENCY;

  typedef enum logic [1:0] {IDLE, INFO, PARITY, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   icnt;
  logic [PW-1:0]   pcnt;
  logic [DW-1:0]   dcnt;
  // Stage 0 is aligned with enc_message; stage L lines up with the matching enc_code byte.
  logic [L:0]      vld_pipe, sof_pipe, eof_pipe;
  logic            push_vld, push_sof, push_eof, abort;
  logic            i_last, p_last, d_last;

  assign i_last = (icnt == IW'(INFO_BYTES - 1));
  assign p_last = (pcnt == PW'(PARITY_BYTES - 1));
  assign d_last = (dcnt == DW'(ENC_LATENCY));
  assign busy   = (state != IDLE) || (|vld_pipe) || out_valid;

  // Next state, handshake and per-byte flag generation
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    push_vld  = 1'b0;
    push_sof  = 1'b0;
    push_eof  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        // Holding off while start or the abort pulse is high guarantees a clear cycle.
        in_ready = !reset && !enc_start && !err_underrun;
        if (in_valid && in_ready) begin
          state_nxt = INFO;
          push_vld  = 1'b1;
          push_sof  = 1'b1;
        end
      end
      INFO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          push_vld = 1'b1;
          if (i_last) state_nxt = PARITY;
        end else begin
          // Encoder cannot stall, so a missing byte kills the frame.
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      PARITY: begin
        push_vld = 1'b1;
        push_eof = p_last;
        if (p_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (d_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Encoder drive and phase counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_message  <= '0;
      enc_sel      <= 1'b1;
      enc_start    <= 1'b0;
      icnt         <= '0;
      pcnt         <= '0;
      dcnt         <= '0;
      err_underrun <= 1'b0;
    end else begin
      err_underrun <= abort;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            enc_message <= in_data;
            enc_sel     <= 1'b1;
            enc_start   <= 1'b1;
            icnt        <= IW'(1);
          end
        end
        INFO: begin
          if (in_valid) begin
            enc_message <= in_data;
            icnt        <= i_last ? '0 : icnt + IW'(1);
            if (i_last) pcnt <= '0;
          end else begin
            enc_message <= '0;
            enc_sel     <= 1'b1;
            enc_start   <= 1'b0;
            icnt        <= '0;
          end
        end
        PARITY: begin
          enc_message <= '0;
          enc_sel     <= 1'b0;
          pcnt        <= p_last ? '0 : pcnt + PW'(1);
          if (p_last) dcnt <= '0;
        end
        DRAIN: begin
          // Last parity byte stays in the encoder until its code byte has been captured.
          enc_message <= '0;
          if (d_last) begin
            enc_start <= 1'b0;
            enc_sel   <= 1'b1;
            dcnt      <= '0;
          end else begin
            enc_sel   <= 1'b0;
            dcnt      <= dcnt + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Flag delay line tracking each byte through the encoder latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset || abort) begin
      vld_pipe <= '0;
      sof_pipe <= '0;
      eof_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[L-1:0], push_vld};
      sof_pipe <= {sof_pipe[L-1:0], push_sof};
      eof_pipe <= {eof_pipe[L-1:0], push_eof};
    end
  end

  // Output register: code byte qualified by the pipeline tail
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      out_data  <= enc_code;
      out_valid <= vld_pipe[L] && !abort;
      out_sof   <= sof_pipe[L] && !abort;
      out_eof   <= eof_pipe[L] && !abort;
    end
  end

endmodule

// File: tb/tb_bch_encoder_p8_ctrl.sv
// Bench for bch_encoder_p8_ctrl: latency-1 and latency-3 instances, each fed by a
// toy delay-line encoder (code = message ^ 0xA5). Expected codewords come from the frame bytes.
module tb_bch_encoder_p8_ctrl;
  localparam int NI = 512;
  localparam int NP = 13;
  localparam int NT = NI + NP;
  localparam int HN = 20000;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0][7:0] in_data, enc_message, enc_code, out_data;
  logic [1:0]      in_valid, in_ready, enc_sel, enc_start;
  logic [1:0]      out_valid, out_sof, out_eof, err_underrun, busy;
  logic [1:0][7:0] d3;

  int checks = 0, errors = 0, cyc = 0;

  logic [7:0] h_msg [2][HN];
  logic [7:0] h_od  [2][HN];
  logic [7:0] h_code[2][HN];
  logic       h_sel [2][HN];
  logic       h_start[2][HN];
  logic       h_rdy [2][HN];
  logic       h_ov  [2][HN];
  logic       h_sof [2][HN];
  logic       h_eof [2][HN];
  logic       h_err [2][HN];
  logic       h_busy[2][HN];
  logic [7:0] fr[2][NI];

  bch_encoder_p8_ctrl #(.INFO_BYTES(NI), .PARITY_BYTES(NP), .ENC_LATENCY(1)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .enc_message(enc_message[0]), .enc_sel(enc_sel[0]),
    .enc_start(enc_start[0]), .enc_code(enc_code[0]), .out_data(out_data[0]),
    .out_valid(out_valid[0]), .out_sof(out_sof[0]), .out_eof(out_eof[0]),
    .err_underrun(err_underrun[0]), .busy(busy[0]));

  bch_encoder_p8_ctrl #(.INFO_BYTES(NI), .PARITY_BYTES(NP), .ENC_LATENCY(3)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .enc_message(enc_message[1]), .enc_sel(enc_sel[1]),
    .enc_start(enc_start[1]), .enc_code(enc_code[1]), .out_data(out_data[1]),
    .out_valid(out_valid[1]), .out_sof(out_sof[1]), .out_eof(out_eof[1]),
    .err_underrun(err_underrun[1]), .busy(busy[1]));

  always #5 clk = ~clk;

  // Cycle n is the interval after the n-th rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // Toy encoders: latency 1 and latency 3, zero while start is low
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_code <= '0;
      d3       <= '0;
    end else begin
      enc_code[0] <= enc_start[0] ? (enc_message[0] ^ 8'hA5) : 8'h00;
      d3[0]       <= enc_start[1] ? (enc_message[1] ^ 8'hA5) : 8'h00;
      d3[1]       <= d3[0];
      enc_code[1] <= d3[1];
    end
  end

  // Per-cycle history, sampled mid-cycle
  always @(negedge clk) begin
    if (cyc < HN) begin
      for (int k = 0; k < 2; k++) begin
        h_msg[k][cyc]   <= enc_message[k];
        h_od[k][cyc]    <= out_data[k];
        h_code[k][cyc]  <= enc_code[k];
        h_sel[k][cyc]   <= enc_sel[k];
        h_start[k][cyc] <= enc_start[k];
        h_rdy[k][cyc]   <= in_ready[k];
        h_ov[k][cyc]    <= out_valid[k];
        h_sof[k][cyc]   <= out_sof[k];
        h_eof[k][cyc]   <= out_eof[k];
        h_err[k][cyc]   <= err_underrun[k];
        h_busy[k][cyc]  <= busy[k];
      end
    end
  end

  initial begin
    #190000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rand_frame(input int s);
    for (int j = 0; j < NI; j++) fr[s][j] = 8'($urandom);
  endtask

  // Valid/ready source; t0/t1 = cycle holding byte 0 of the first/second frame on enc_message
  task automatic drive(input int k, input int nbytes, input int drop_at,
                       output int t0, output int t1);
    int idx, guard;
    logic done;
    idx = 0; guard = 0; t0 = -1; t1 = -1;
    while (idx < nbytes && idx != drop_at && guard < 4000) begin
      @(negedge clk);
      guard++;
      in_valid[k] = 1'b1;
      in_data[k]  = fr[idx / NI][idx % NI];
      #1;
      if (in_ready[k]) begin
        if (idx == 0)  t0 = cyc + 1;
        if (idx == NI) t1 = cyc + 1;
        idx++;
      end
    end
    @(negedge clk);
    in_valid[k] = 1'b0;
    done = (idx == nbytes) || (idx == drop_at);
    chk("drive_complete", done, 1);
  endtask

  task automatic check_frame(input int k, input int s, input int t0, input int lat,
                             input logic idle_after);
    int bad, cnt, first, c;
    logic [7:0] e;
    bad = 0;
    for (int j = 0; j < NI; j++)
      if (h_msg[k][t0+j] !== fr[s][j] || h_sel[k][t0+j] !== 1'b1 || h_start[k][t0+j] !== 1'b1) bad++;
    chk("info_phase_bad", bad, 0);
    bad = 0;
    for (int j = NI; j < NT; j++)
      if (h_msg[k][t0+j] !== 8'h00 || h_sel[k][t0+j] !== 1'b0 || h_start[k][t0+j] !== 1'b1) bad++;
    chk("parity_phase_bad", bad, 0);
    bad = 0;
    for (int j = 0; j < NT; j++) begin
      c = t0 + lat + 1 + j;
      e = ((j < NI) ? fr[s][j] : 8'h00) ^ 8'hA5;
      if (h_ov[k][c] !== 1'b1 || h_od[k][c] !== e || h_od[k][c] !== h_code[k][c-1]) bad++;
    end
    chk("out_bytes_bad", bad, 0);
    cnt = 0; first = -1;
    for (int i = t0; i <= t0 + lat + NT; i++)
      if (h_sof[k][i] === 1'b1) begin cnt++; if (first < 0) first = i; end
    chk("sof_count", cnt, 1);
    chk("sof_cycle", first - t0, lat + 1);
    cnt = 0; first = -1;
    for (int i = t0; i <= t0 + lat + NT + 2; i++)
      if (h_eof[k][i] === 1'b1) begin cnt++; if (first < 0) first = i; end
    chk("eof_count", cnt, 1);
    chk("eof_cycle", first - t0, NT + lat);
    chk("ov_before_frame", h_ov[k][t0+lat], 0);
    chk("ov_after_frame", h_ov[k][t0+lat+NT+1], 0);
    chk("start_high_last", h_start[k][t0+NT+lat-1], 1);
    chk("start_fall", h_start[k][t0+NT+lat], 0);
    chk("busy_mid", h_busy[k][t0+300], 1);
    if (idle_after) chk("busy_end", h_busy[k][t0+NT+lat+1], 0);
  endtask

  initial begin
    int t0, t1, r, bad, cnt;
    reset = 1'b1; in_valid = '0; in_data = '0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready", in_ready[k], 0);
      chk("rst_enc_message", enc_message[k], 0);
      chk("rst_enc_sel", enc_sel[k], 1);
      chk("rst_enc_start", enc_start[k], 0);
      chk("rst_out", {out_data[k], out_valid[k], out_sof[k], out_eof[k]}, 0);
      chk("rst_err_busy", {err_underrun[k], busy[k]}, 0);
    end

    // Idle stream
    @(negedge clk); reset = 1'b0; r = cyc;
    repeat (1002) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bad = 0;
      for (int c = r + 1; c <= r + 1000; c++)
        if (h_start[k][c] !== 1'b0 || h_ov[k][c] !== 1'b0 || h_busy[k][c] !== 1'b0 || h_rdy[k][c] !== 1'b1) bad++;
      chk("idle_stream_bad", bad, 0);
    end

    // Single frame, counting bytes
    for (int j = 0; j < NI; j++) fr[0][j] = 8'(j);
    drive(0, NI, -1, t0, t1);
    repeat (600) @(negedge clk);
    check_frame(0, 0, t0, 1, 1'b1);

    // Back-to-back frames
    rand_frame(0); rand_frame(1);
    drive(0, 2 * NI, -1, t0, t1);
    repeat (600) @(negedge clk);
    chk("b2b_period", t1 - t0, 527);
    check_frame(0, 0, t0, 1, 1'b0);
    check_frame(0, 1, t1, 1, 1'b1);
    chk("b2b_start_single_low", {h_start[0][t0+525], h_start[0][t0+526], h_start[0][t0+527]}, 3'b101);
    bad = 0;
    for (int c = t0 + 512; c <= t0 + 525; c++) if (h_rdy[0][c] !== 1'b0) bad++;
    chk("b2b_ready_low", bad, 0);
    chk("b2b_ready_back", h_rdy[0][t0+526], 1);

    // Underrun at byte 100, then a clean frame
    rand_frame(0);
    drive(0, NI, 100, t0, t1);
    repeat (200) @(negedge clk);
    cnt = 0;
    for (int c = t0; c < t0 + 200; c++) if (h_err[0][c] === 1'b1) cnt++;
    chk("ur_err_count", cnt, 1);
    chk("ur_err_cycle", h_err[0][t0+100], 1);
    chk("ur_start_low", h_start[0][t0+100], 0);
    cnt = 0;
    for (int c = t0; c < t0 + 200; c++) if (h_eof[0][c] === 1'b1) cnt++;
    chk("ur_no_eof", cnt, 0);
    bad = 0;
    for (int c = t0 + 102; c < t0 + 200; c++) if (h_ov[0][c] !== 1'b0) bad++;
    chk("ur_valid_stops", bad, 0);
    bad = 0;
    for (int j = 0; j < 98; j++)
      if (h_ov[0][t0+2+j] !== 1'b1 || h_od[0][t0+2+j] !== (fr[0][j] ^ 8'hA5)) bad++;
    chk("ur_partial_bytes", bad, 0);
    chk("ur_ready_after_err", {h_rdy[0][t0+100], h_rdy[0][t0+101]}, 2'b01);
    chk("ur_busy_clear", h_busy[0][t0+101], 0);
    rand_frame(0);
    drive(0, NI, -1, t0, t1);
    repeat (600) @(negedge clk);
    check_frame(0, 0, t0, 1, 1'b1);

    // Reset during parity byte 5
    rand_frame(0);
    drive(0, NI, -1, t0, t1);
    while (cyc < t0 + 517) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mr_was_parity", h_sel[0][t0+517], 0);
    chk("mr_in_ready", in_ready[0], 0);
    chk("mr_enc", {enc_message[0], enc_sel[0], enc_start[0]}, {8'h00, 1'b1, 1'b0});
    chk("mr_out", {out_data[0], out_valid[0], out_sof[0], out_eof[0]}, 0);
    chk("mr_err_busy", {err_underrun[0], busy[0]}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    cnt = 0;
    for (int c = t0; c < cyc; c++) if (h_err[0][c] === 1'b1) cnt++;
    chk("mr_no_err", cnt, 0);
    rand_frame(0);
    drive(0, NI, -1, t0, t1);
    repeat (600) @(negedge clk);
    check_frame(0, 0, t0, 1, 1'b1);

    // Encoder latency 3
    rand_frame(0);
    drive(1, NI, -1, t0, t1);
    repeat (600) @(negedge clk);
    check_frame(1, 0, t0, 3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
